gen_regfile_mp: RTL and testbench
=================================

GEN_REGFILE_MP -- requirements
Module: gen_regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREG, default 32, number of registers (power of two, at least 2); AW = $clog2(NREG).
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Parameter NWR, default 2, number of write ports (1..2).
REQ-005 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port `rs_addr`, input, NRD x AW: read address, one per read port.
REQ-008 Port `rs_data`, output, NRD x XLEN: read data, one per read port.
REQ-009 Port `rs_busy`, output, NRD: scoreboard busy bit of the addressed register, one per read port.
REQ-010 Port `wr_en`, input, NWR: write enable, one per write port.
REQ-011 Port `wr_addr`, input, NWR x AW: write address.
REQ-012 Port `wr_data`, input, NWR x XLEN: write data.
REQ-013 Port `iss_en`, input, 1 bit: issue request that marks `iss_addr` busy.
REQ-014 Port `iss_addr`, input, AW: destination register of the issuing instruction.
REQ-015 Port `iss_ready`, output, 1 bit: high when `iss_addr` is not busy.
REQ-016 Port `flush`, input, 1 bit: clears all busy bits.
REQ-017 Port `busy_cnt`, output, $clog2(NREG+1): registered count of busy registers.

Function
REQ-018 Register 0 SHALL read zero and SHALL never be busy; writes and issues to it SHALL be ignored, on every port independently.
REQ-019 Reads SHALL be combinational: `rs_data[p]` returns the register addressed by `rs_addr[p]`.
REQ-020 Writes SHALL take effect at the rising edge; same-address writes in one cycle SHALL resolve with the highest-index port winning.
REQ-021 A write to register r SHALL clear busy[r] at the same edge.
REQ-022 `iss_en` with `iss_ready` high and `iss_addr` != 0 SHALL set busy[`iss_addr`] at the edge.
REQ-023 `iss_en` with `iss_ready` low SHALL be dropped, with no state change.
REQ-024 Set and clear of the same register in one cycle SHALL leave it busy (the new producer wins).
REQ-025 `flush` SHALL clear every busy bit at the edge and SHALL drop a coincident issue; register contents SHALL be unaffected and writes in that cycle SHALL still complete.
REQ-026 `busy_cnt` SHALL equal the population count of the busy vector after every edge, with no lag.

Reset
REQ-027 While `rst` is high: all registers, busy bits and `busy_cnt` SHALL be 0, `rs_data` and `rs_busy` SHALL be 0, and `iss_ready` SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard that cycle's writes and issues.

Configuration
REQ-029 With `RF_BYPASS_EN` defined: a same-cycle write to the read address SHALL forward `wr_data` to `rs_data` (highest matching port wins), force `rs_busy` to 0, and `iss_ready` SHALL count a same-cycle write to `iss_addr` as clearing it.
REQ-030 Without `RF_BYPASS_EN`: reads and `iss_ready` SHALL reflect registered state only, and a write is visible from the next cycle.

Structure
REQ-031 A shared package SHALL hold the XLEN/NREG defaults, the AW derivation, the zero-word constant, and the read-port and write-port request typedefs.
REQ-032 One sub-module, `rf_scoreboard`, SHALL hold the busy vector, the issue/clear/flush logic and `busy_cnt`; the storage array stays in the top module.

Verification
REQ-033 Scenario: write x5=0xDEADBEEF, then read x5 next cycle on both ports -> both ports return 0xDEADBEEF.
REQ-034 Scenario: port0 writes x7=0x1 and port1 writes x7=0x2 in the same cycle -> x7 reads 0x2.
REQ-035 Scenario: write x0=0xFFFFFFFF and issue x0 -> x0 reads 0, `busy_cnt`=0, `rs_busy`=0.
REQ-036 Scenario: issue x3 -> `busy_cnt`=1; re-issue x3 -> `iss_ready`=0 and the issue is dropped; write x3 together with issue x3 -> x3 remains busy and `busy_cnt`=1.
REQ-037 Scenario: with `RF_BYPASS_EN`, read x9 while writing x9=0x55 -> `rs_data`=0x55 in the same cycle; without the macro -> old value this cycle, 0x55 the next.
REQ-038 Scenario: busy x1,x2,x4, then `flush` with issue x6 -> `busy_cnt`=0 and x6 not busy; assert `rst` mid-write -> all reads 0 after release.

Source files
------------

// File: rtl/gen_regfile_mp_pkg.sv
// Shared defaults, address-width helper and request typedefs for the multi-port register file.
package gen_regfile_mp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

  function automatic int addr_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic                en;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, flush wipes; keeps a registered popcount.
// Optional RF_BYPASS_EN lets a same-cycle writeback make the issue target ready.
module rf_scoreboard
  import gen_regfile_mp_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = addr_w(NREG),
  parameter int CW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREG-1:0] clr_vec,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic            iss_ready,
  output logic [CW-1:0]   busy_cnt
);

  logic            iss_fire;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] busy_nxt;

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  always_comb begin
`ifdef RF_BYPASS_EN
    iss_ready = !rst && (!busy[iss_addr] || clr_vec[iss_addr]);
`else
    iss_ready = !rst && !busy[iss_addr];
`endif
    iss_fire = iss_en && iss_ready && !flush && (iss_addr != '0);
    set_vec  = '0;
    if (iss_fire) set_vec[iss_addr] = 1'b1;
    // set after clear: a new producer overrides a retiring one on the same register
    busy_nxt    = flush ? '0 : ((busy & ~clr_vec) | set_vec);
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

endmodule

// File: rtl/gen_regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and an issue scoreboard.
// Optional RF_BYPASS_EN forwards same-cycle writes to reads and to the issue-ready check.
module gen_regfile_mp
  import gen_regfile_mp_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = addr_w(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRD-1:0][AW-1:0]    rs_addr,
  output logic [NRD-1:0][XLEN-1:0]  rs_data,
  output logic [NRD-1:0]            rs_busy,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR-1:0][AW-1:0]    wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_addr,
  output logic                      iss_ready,
  input  logic                      flush,
  output logic [CW-1:0]             busy_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr_vec;

  always_comb begin
    clr_vec = '0;
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && (wr_addr[p] != '0)) clr_vec[wr_addr[p]] = 1'b1;
  end

  // loop order makes the highest-index port the last assignment, so it wins on collisions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && (wr_addr[p] != '0)) regs[wr_addr[p]] <= wr_data[p];
    end
  end

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    if (!rst) begin
      for (int p = 0; p < NRD; p++) begin
        rs_data[p] = regs[rs_addr[p]];
        rs_busy[p] = busy[rs_addr[p]];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_addr[w] == rs_addr[p]) && (wr_addr[w] != '0)) begin
            rs_data[p] = wr_data[w];
            rs_busy[p] = 1'b0;
          end
        end
`endif
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .CW   (CW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .clr_vec   (clr_vec),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .busy      (busy),
    .iss_ready (iss_ready),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_gen_regfile_mp.sv
// Directed bench for gen_regfile_mp: driver queues expected outputs, a negedge monitor checks them.
module tb_gen_regfile_mp;
  import gen_regfile_mp_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [2:0] K_D0 = 3'd0, K_D1 = 3'd1, K_B0 = 3'd2, K_B1 = 3'd3,
                         K_RDY = 3'd4, K_CNT = 3'd5;

  logic                     clk;
  logic                     rst;
  logic [NRD-1:0][AW-1:0]   rs_addr;
  logic [NRD-1:0][XLEN-1:0] rs_data;
  logic [NRD-1:0]           rs_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     iss_ready;
  logic                     flush;
  logic [CW-1:0]            busy_cnt;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  gen_regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs_addr),
    .rs_data   (rs_data),
    .rs_busy   (rs_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      string       n;
      logic [31:0] act;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (e.kind)
        K_D0:    act = rs_data[0];
        K_D1:    act = rs_data[1];
        K_B0:    act = {31'b0, rs_busy[0]};
        K_B1:    act = {31'b0, rs_busy[1]};
        K_RDY:   act = {31'b0, iss_ready};
        default: act = {26'b0, busy_cnt};
      endcase
      n_total++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, e.val, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic wr_req_t mk_wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_req_t r;
    r.en   = 1'b1;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    flush    = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int port, input wr_req_t r);
    wr_en[port]   = r.en;
    wr_addr[port] = r.addr;
    wr_data[port] = r.data;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_en   = 1'b1;
    iss_addr = a;
  endtask

  task automatic expect_val(input logic [2:0] k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    rd_req_t rq;
    idle();
    rst = 1'b1;
    rq.addr = 5'd5;
    rs_addr[0] = rq.addr;
    rs_addr[1] = rq.addr;
    @(posedge clk);
    #1;
    expect_val(K_D0, ZERO_WORD, "reset_rs_data");
    expect_val(K_B0, 0, "reset_rs_busy");
    expect_val(K_RDY, 0, "reset_iss_ready");
    expect_val(K_CNT, 0, "reset_busy_cnt");
    next_cyc();
    rst = 1'b0;

    // write then read on both ports
    next_cyc();
    wr(0, mk_wr(5'd5, 32'hDEADBEEF));
    expect_val(K_D0, BYP ? 32'hDEADBEEF : 32'h0, "x5_same_cycle");
    next_cyc();
    expect_val(K_D0, 32'hDEADBEEF, "x5_port0");
    expect_val(K_D1, 32'hDEADBEEF, "x5_port1");

    // same-address collision, port1 wins
    next_cyc();
    wr(0, mk_wr(5'd7, 32'h1));
    wr(1, mk_wr(5'd7, 32'h2));
    next_cyc();
    rs_addr[0] = 5'd7;
    expect_val(K_D0, 32'h2, "x7_collision");
    expect_val(K_D1, 32'hDEADBEEF, "x5_kept");

    // x0 write and issue ignored
    next_cyc();
    rs_addr[0] = 5'd0;
    rs_addr[1] = 5'd0;
    wr(0, mk_wr(5'd0, 32'hFFFFFFFF));
    issue(5'd0);
    expect_val(K_D0, 0, "x0_during_write");
    expect_val(K_RDY, 1, "x0_ready");
    next_cyc();
    expect_val(K_D0, 0, "x0_reads_zero");
    expect_val(K_B0, 0, "x0_not_busy");
    expect_val(K_CNT, 0, "x0_cnt");

    // issue, dropped re-issue, write+issue
    next_cyc();
    rs_addr[0] = 5'd3;
    issue(5'd3);
    expect_val(K_RDY, 1, "x3_ready_first");
    next_cyc();
    issue(5'd3);
    expect_val(K_RDY, 0, "x3_reissue_blocked");
    expect_val(K_CNT, 1, "x3_cnt_one");
    expect_val(K_B0, 1, "x3_busy");
    next_cyc();
    wr(0, mk_wr(5'd3, 32'hAA));
    issue(5'd3);
    expect_val(K_RDY, BYP ? 1 : 0, "x3_ready_with_write");
    expect_val(K_CNT, 1, "x3_cnt_after_drop");
    expect_val(K_B0, BYP ? 0 : 1, "x3_busy_with_write");
    next_cyc();
    expect_val(K_CNT, BYP ? 1 : 0, "x3_cnt_after_wr_iss");
    expect_val(K_B0, BYP ? 1 : 0, "x3_busy_after_wr_iss");
    next_cyc();
    wr(0, mk_wr(5'd3, 32'hBB));
    issue(5'd3);
    expect_val(K_RDY, 1, "x3_ready_set_clear");
    next_cyc();
    expect_val(K_CNT, 1, "x3_cnt_set_wins");
    expect_val(K_B0, 1, "x3_busy_set_wins");
    expect_val(K_D0, 32'hBB, "x3_data");

    // bypass visibility
    next_cyc();
    rs_addr[0] = 5'd9;
    wr(1, mk_wr(5'd9, 32'h55));
    expect_val(K_D0, BYP ? 32'h55 : 32'h0, "x9_same_cycle");
    next_cyc();
    expect_val(K_D0, 32'h55, "x9_next_cycle");

    // busy x1,x2,x4 then flush with coincident issue and write
    wr(0, mk_wr(5'd3, 32'hCC));
    next_cyc();
    issue(5'd1);
    expect_val(K_CNT, 0, "cnt_before_iss1");
    next_cyc();
    issue(5'd2);
    expect_val(K_CNT, 1, "cnt_after_iss1");
    next_cyc();
    issue(5'd4);
    expect_val(K_CNT, 2, "cnt_after_iss2");
    next_cyc();
    flush = 1'b1;
    issue(5'd6);
    wr(1, mk_wr(5'd10, 32'h77));
    expect_val(K_CNT, 3, "cnt_before_flush");
    next_cyc();
    rs_addr[0] = 5'd6;
    rs_addr[1] = 5'd10;
    expect_val(K_CNT, 0, "cnt_after_flush");
    expect_val(K_B0, 0, "x6_not_busy");
    expect_val(K_D1, 32'h77, "flush_write_done");
    next_cyc();
    rs_addr[0] = 5'd5;
    expect_val(K_D0, 32'hDEADBEEF, "flush_keeps_data");

    // reset in the middle of a write
    next_cyc();
    wr(0, mk_wr(5'd11, 32'h99));
    issue(5'd12);
    rst = 1'b1;
    expect_val(K_D0, 0, "rst_mid_rs_data");
    expect_val(K_RDY, 0, "rst_mid_ready");
    next_cyc();
    rst = 1'b0;
    rs_addr[0] = 5'd5;
    rs_addr[1] = 5'd11;
    expect_val(K_D0, 0, "post_rst_x5");
    expect_val(K_D1, 0, "post_rst_x11");
    expect_val(K_CNT, 0, "post_rst_cnt");
    next_cyc();
    rs_addr[0] = 5'd7;
    rs_addr[1] = 5'd9;
    expect_val(K_D0, 0, "post_rst_x7");
    expect_val(K_D1, 0, "post_rst_x9");
    expect_val(K_RDY, 1, "post_rst_ready");

    next_cyc();
    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
